// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between a 1-cycle-latency
// instruction memory and decode.
// Words are issued sequentially, buffered with their PC in a small FIFO,
// and presented to decode under a valid/ready handshake. A redirect flushes
// the queue and restarts fetch at the target.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a returning word straight to
// decode when the FIFO is empty, which saves one cycle of latency.
module fetch_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_i,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc_i,
  output logic                       imem_req_o,
  output logic [ADDR_WIDTH-1:0]      imem_addr_o,
  input  logic [INSTR_WIDTH-1:0]     imem_rdata_i,
  output logic [INSTR_WIDTH-1:0]     instr_o,
  output logic [ADDR_WIDTH-1:0]      pc_o,
  output logic [ADDR_WIDTH-1:0]      pc_plus4_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [ADDR_WIDTH-1:0]  last_pc;
  logic [ADDR_WIDTH-1:0]  issue_addr;
  logic [ADDR_WIDTH-1:0]  head_pc;
  logic                   inflight;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W:0]         count;
  logic [PTR_W+1:0]       credit;
  logic                   fifo_valid;
  logic                   push;
  logic                   pop;
`ifdef FETCH_QUEUE_BYPASS_EN
  logic                   bypass;
`endif

  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

  // Request generation, push/pop decisions and head-of-queue output mux.
  // Credits count occupancy plus the in-flight word so the FIFO can never
  // overflow; a same-cycle pop is deliberately not credited.
  always_comb begin
    credit     = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight};
    issue_addr = redirect_i ? {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00} : fetch_pc;
    imem_req_o = !rst && (redirect_i || (credit < (PTR_W+2)'(DEPTH)));
    fifo_valid = (count != '0) && !redirect_i;
    pop        = fifo_valid && ready_i;
    valid_o    = fifo_valid;
    instr_o    = (count != '0) ? instr_mem[rd_ptr] : NOP;
    head_pc    = (count != '0) ? pc_mem[rd_ptr] : last_pc;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass     = inflight && (count == '0) && !redirect_i;
    push       = inflight && !redirect_i && !(bypass && ready_i);
    if (bypass) begin
      valid_o  = 1'b1;
      instr_o  = imem_rdata_i;
      head_pc  = pc_q;
    end
`else
    push       = inflight && !redirect_i;
`endif
    pc_o       = head_pc;
    pc_plus4_o = head_pc + ADDR_WIDTH'(4);
    imem_addr_o = issue_addr;
    count_o    = count;
  end

  // Fetch PC, in-flight tracking and FIFO pointer/occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pc_q     <= '0;
      last_pc  <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req_o;
      last_pc  <= head_pc;
      if (imem_req_o) begin
        fetch_pc <= issue_addr + ADDR_WIDTH'(4);
        pc_q     <= issue_addr;
      end
      if (redirect_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_q;
      instr_mem[wr_ptr] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue.
// The memory model returns addr>>2 one cycle after each request.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int FIRST      = 1;
  localparam int STEADY_CNT = 0;
`else
  localparam int FIRST      = 2;
  localparam int STEADY_CNT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  count_o;

  int tests_run;
  int tests_failed;

  fetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .count_o       (count_o)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory whose word at address A is A>>2.
  always @(posedge clk) begin
    if (imem_req_o) imem_rdata <= imem_addr_o >> 2;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance to the next cycle, drive inputs (releasing reset), settle.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                               input logic rdy);
    @(negedge clk);
    rst           = 1'b0;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    ready_i       = rdy;
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'd0);
    checkOutput({tag, "_count"}, 32'(count_o), 32'd0);
    checkOutput({tag, "_req"},   32'(imem_req_o), 32'd0);
    checkOutput({tag, "_instr"}, instr_o, 32'h0000_0013);
    checkOutput({tag, "_pc"},    pc_o, 32'd0);
    checkOutput({tag, "_pc4"},   pc_plus4_o, 32'd4);
  endtask

  // Hold reset across one rising edge; the next applyStimulus releases it.
  task automatic resetDut();
    @(negedge clk);
    rst        = 1'b1;
    redirect_i = 1'b0;
    ready_i    = 1'b0;
    #1;
    checkResetValues("rst");
  endtask

  // Streaming from reset release with ready held high.
  task automatic streamCheck(input string tag);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput({tag, "_req"},  32'(imem_req_o), 32'd1);
      checkOutput({tag, "_addr"}, imem_addr_o, 32'(4 * k));
      if (k < FIRST) begin
        checkOutput({tag, "_valid_early"}, 32'(valid_o), 32'd0);
      end else begin
        checkOutput({tag, "_valid"}, 32'(valid_o), 32'd1);
        checkOutput({tag, "_pc"},    pc_o, 32'(4 * (k - FIRST)));
        checkOutput({tag, "_instr"}, instr_o, 32'(k - FIRST));
        checkOutput({tag, "_pc4"},   pc_plus4_o, 32'(4 * (k - FIRST) + 4));
        checkOutput({tag, "_count"}, 32'(count_o), 32'(STEADY_CNT));
      end
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    ready_i       = 1'b0;
    imem_rdata    = 32'd0;

    // Reset values and the basic streaming sequence.
    resetDut();
    streamCheck("stream");

    // Backpressure: fill to DEPTH, then drain and resume at 16.
    resetDut();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("bp_req",  32'(imem_req_o), 32'd1);
      checkOutput("bp_addr", imem_addr_o, 32'(4 * k));
      if (k == 1) checkOutput("bp_valid_c1", 32'(valid_o), 32'(FIRST == 1));
      if (k == 2) checkOutput("bp_count_c2", 32'(count_o), 32'd1);
    end
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("bp_req_c4",   32'(imem_req_o), 32'd0);
    checkOutput("bp_count_c4", 32'(count_o), 32'd3);
    for (int k = 5; k < 7; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("bp_req_full",   32'(imem_req_o), 32'd0);
      checkOutput("bp_count_full", 32'(count_o), 32'd4);
      checkOutput("bp_valid_full", 32'(valid_o), 32'd1);
      checkOutput("bp_pc_full",    pc_o, 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("bp_req_c7",   32'(imem_req_o), 32'd0);
    checkOutput("bp_pc_c7",    pc_o, 32'd0);
    checkOutput("bp_count_c7", 32'(count_o), 32'd4);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("bp_req_c8",   32'(imem_req_o), 32'd1);
    checkOutput("bp_addr_c8",  imem_addr_o, 32'd16);
    checkOutput("bp_pc_c8",    pc_o, 32'd4);
    checkOutput("bp_count_c8", 32'(count_o), 32'd3);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("bp_addr_c9",  imem_addr_o, 32'd20);
    checkOutput("bp_pc_c9",    pc_o, 32'd8);
    checkOutput("bp_count_c9", 32'(count_o), 32'd2);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("bp_pc_c10",   pc_o, 32'd12);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("bp_pc_c11",    pc_o, 32'd16);
    checkOutput("bp_instr_c11", instr_o, 32'd4);
    checkOutput("bp_count_c11", 32'(count_o), 32'd2);

    // Redirect to an unaligned target with count=3 and a word in flight.
    resetDut();
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h103, 1'b0);
    checkOutput("rd_req",   32'(imem_req_o), 32'd1);
    checkOutput("rd_addr",  imem_addr_o, 32'h100);
    checkOutput("rd_valid", 32'(valid_o), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("rd_count_next", 32'(count_o), 32'd0);
    checkOutput("rd_valid_next", 32'(valid_o), 32'(FIRST == 1));
    if (FIRST == 1) checkOutput("rd_pc_bypass", pc_o, 32'h100);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("rd_valid_2", 32'(valid_o), 32'd1);
    checkOutput("rd_pc_2",    pc_o, 32'h100);
    checkOutput("rd_instr_2", instr_o, 32'h40);
    checkOutput("rd_pc4_2",   pc_plus4_o, 32'h104);
    checkOutput("rd_count_2", 32'(count_o), 32'd1);

    // Back-to-back redirects: only the second target survives.
    resetDut();
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 32'h40, 1'b1);
    checkOutput("bb_addr_1",  imem_addr_o, 32'h40);
    checkOutput("bb_valid_1", 32'(valid_o), 32'd0);
    applyStimulus(1'b1, 32'h80, 1'b1);
    checkOutput("bb_addr_2",  imem_addr_o, 32'h80);
    checkOutput("bb_valid_2", 32'(valid_o), 32'd0);
    for (int k = 6; k < 11; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b1);
      if (k < 5 + FIRST) begin
        checkOutput("bb_valid_early", 32'(valid_o), 32'd0);
      end else begin
        checkOutput("bb_valid", 32'(valid_o), 32'd1);
        checkOutput("bb_pc",    pc_o, 32'(32'h80 + 4 * (k - 5 - FIRST)));
        checkOutput("bb_instr", instr_o, 32'(32'h20 + (k - 5 - FIRST)));
      end
    end

    // Reset asserted mid-stream with two words buffered.
    resetDut();
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("mid_count_pre", 32'(count_o), 32'd2);
    checkOutput("mid_instr_pre", instr_o, 32'd0);
    rst = 1'b1;
    #1;
    checkResetValues("mid");
    streamCheck("restream");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer between instruction memory and the decode/control stage.
- Issues sequential fetches to a synchronous instruction memory with a fixed 1-cycle read latency.
- Buffers returned words with their PC in a small FIFO and presents one instruction per cycle to decode under a valid/ready handshake.
- Flushes on a taken branch or jump redirect and restarts fetch at the redirect target.

Parameters:
- INSTR_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC and fetch address width.
- DEPTH, 4, FIFO entries. Power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  Clock; all state updates on the rising edge.
- rst  input  1  Reset; asynchronous, active-high.
- redirect_i  input  1  Taken branch/jump from execute; flush and refetch.
- redirect_pc_i  input  ADDR_WIDTH  Redirect target.
- imem_req_o  output  1  Fetch request this cycle.
- imem_addr_o  output  ADDR_WIDTH  Fetch address, word aligned.
- imem_rdata_i  input  INSTR_WIDTH  Read data for the request issued in the previous cycle.
- instr_o  output  INSTR_WIDTH  Head instruction to decode.
- pc_o  output  ADDR_WIDTH  PC of head instruction.
- pc_plus4_o  output  ADDR_WIDTH  pc_o + 4, used for link writeback.
- valid_o  output  1  Head entry valid.
- ready_i  input  1  Decode accepts head this cycle.
- count_o  output  $clog2(DEPTH)+1  Current FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-high):
  - fetch_pc = RESET_PC; FIFO empty; inflight = 0.
  - valid_o = 0, count_o = 0, imem_req_o = 0.
  - instr_o = 32'h0000_0013 (NOP), pc_o = 0, pc_plus4_o = 4.
  - Reset asserted mid-operation discards all FIFO and in-flight state immediately.
- Internal state: fetch_pc register; inflight flag (a request was issued last cycle); FIFO of {pc, instr} with read/write pointers and a count.
- Request generation (combinational):
  - imem_req_o = !rst && (redirect_i || (count + inflight) < DEPTH).
  - Address: redirect_i ? {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00} : fetch_pc.
  - Redirect targets have bits [1:0] forced to 0.
  - Credit counting ignores a same-cycle pop. Occupancy plus in-flight never exceeds DEPTH, so the FIFO never overflows.
- On a cycle with imem_req_o = 1:
  - fetch_pc <= issued address + 4; inflight <= 1.
  - A pc_q register, holding the address of the in-flight request, <= issued address.
- On a cycle with imem_req_o = 0: inflight <= 0.
- Response: when inflight = 1 and redirect_i = 0, push {pc_q, imem_rdata_i} into the FIFO at the clock edge. If redirect_i = 1 in that cycle, drop the response.
- Dequeue: pop when valid_o && ready_i.
- valid_o = (count != 0) && !redirect_i.
- instr_o, pc_o and pc_plus4_o are driven from the head entry. When the FIFO is empty they hold the NOP, the last head PC, and that PC + 4.
- Simultaneous push and pop: count unchanged; both pointers advance; pointers wrap modulo DEPTH.
- Redirect:
  - In the redirect cycle, count, read pointer and write pointer reset to 0, and no pop occurs.
  - The new request at the redirect target issues in the same cycle.
  - Its data enqueues in the next cycle, and valid_o rises 2 cycles after the redirect.
- Back-to-back redirects: each one restarts fetch; only the latest target survives.
- Latency:
  - Reset release → first imem_req_o in cycle 0 → data enqueued at end of cycle 1 → valid_o = 1 in cycle 2.
  - Steady-state throughput is 1 instruction/cycle when ready_i is held high and DEPTH >= 2.
- Backpressure:
  - With ready_i = 0, the FIFO fills to DEPTH and requests stop.
  - Requests resume the cycle after count + inflight drops below DEPTH.
- fetch_pc wraps modulo 2^ADDR_WIDTH.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count = 0, inflight = 1 and redirect_i = 0, the response drives instr_o/pc_o combinationally and valid_o = 1 in the same cycle.
  - If ready_i = 1, the word is consumed and not written to the FIFO; otherwise it is enqueued normally.
  - First valid_o after reset moves to cycle 1; redirect-to-valid latency becomes 1 cycle.
- Not defined: no bypass; every instruction passes through the FIFO with the latencies given above.

Test Plan:
- Reset release, RESET_PC=0, ready_i=1, memory returns addr>>2:
  - Addresses 0,4,8,… issue once per cycle.
  - valid_o first high in cycle 2 with pc_o=0, instr_o=0, pc_plus4_o=4.
  - Consecutive PCs follow with no gaps.
- ready_i=0 from reset:
  - count_o saturates at 4 and imem_req_o drops.
  - Exactly 4 requests are issued in total (addresses 0,4,8,12).
  - Raise ready_i: pops proceed in order and fetch resumes at 16.
- Redirect to 0x103 while count=3 and a response is in flight:
  - Same cycle: imem_addr_o=0x100, valid_o=0, count_o=0 next cycle.
  - Stale response dropped.
  - Next head has pc_o=0x100 two cycles later.
- Redirects in 2 consecutive cycles (0x40, then 0x80): no instruction from 0x40 ever appears; first valid pc_o=0x80.
- Assert rst mid-stream with count=2: outputs return to reset values immediately; the post-release sequence matches the first scenario.
- With FETCH_QUEUE_BYPASS_EN defined:
  - First valid_o in cycle 1 after reset release; count_o stays 0 with ready_i=1.
  - With ready_i=0, the bypassed word is enqueued and count_o=1.
